pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, 3, register-address width.
REQ-002 SHALL have parameter CNT_W, 8, width of the stall and flush event counters.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, rising-edge clock shared with the pipeline latches.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports id_ra/id_rb, input, REG_AW, source registers of the instruction at the L1 output (stage 2).
REQ-007 SHALL have ports id_uses_ra/id_uses_rb, input, 1, qualifiers for those sources.
REQ-008 SHALL have ports ex_rd, ex_regwrite, ex_memread, input, REG_AW/1/1, destination and controls at the L2 output (stage 3).
REQ-009 SHALL have ports mem_rd, mem_regwrite, input, REG_AW/1, destination and write-enable at the L3 output (stage 4).
REQ-010 SHALL have port br_taken, input, 1, stage-3 branch resolved taken.
REQ-011 SHALL have ports halt_req and cnt_clr, input, 1 each, level halt request and synchronous counter clear.
REQ-012 SHALL have ports pc_en and l1_en, output, 1 each, PC and L1 load enables.
REQ-013 SHALL have ports l1_flush and l2_flush, output, 1 each, bubble-insert controls (zero all control bits captured by that latch).
REQ-014 SHALL have ports fwd_a_sel and fwd_b_sel, output, 2 each, registered ALU-operand selects: 00 regfile, 01 L3 ALU result, 10 writeback mux.
REQ-015 SHALL have ports halted, stall_cnt and flush_cnt, output, 1/CNT_W/CNT_W, status and event counters.

Function
REQ-016 SHALL implement FSM states RUN, STALL, FLUSH, DRAIN, HALTED.
REQ-017 Load-use SHALL be detected when ex_memread & ex_regwrite and ex_rd equals a used id source.
REQ-018 Load-use detected in RUN SHALL combinationally drive pc_en=0, l1_en=0, l2_flush=1 and enter STALL for exactly one cycle, then return to RUN.
REQ-019 br_taken in RUN or STALL SHALL combinationally drive l1_flush=1, l2_flush=1, pc_en=1 and enter FLUSH; FLUSH SHALL return to RUN next cycle with no further flushes.
REQ-020 br_taken and load-use in the same cycle SHALL be resolved with branch priority: no stall, flush_cnt increments, stall_cnt does not.
REQ-021 Forward selects SHALL be computed from the stage-2 instruction and registered on every clock where L2 advances (l2_flush=0).
REQ-022 Forward priority SHALL be ex match (ex_regwrite & !ex_memread) -> 01, else mem match (mem_regwrite) -> 10, else 00; an unused source always selects 00.
REQ-023 A clock with l2_flush=1 SHALL register fwd_*_sel=00.
REQ-024 halt_req in RUN SHALL enter DRAIN with pc_en=0, l1_en=0, l1_flush=1; a 2-bit drain counter SHALL count 3 cycles, then enter HALTED.
REQ-025 HALTED SHALL hold pc_en=0, l1_en=0, halted=1; halt_req deassert SHALL return to RUN next cycle.
REQ-026 halt_req during STALL or FLUSH SHALL be honoured only after return to RUN.
REQ-027 br_taken during DRAIN SHALL be ignored for state purposes but SHALL still assert l2_flush that cycle.
REQ-028 stall_cnt SHALL increment once per STALL entry and flush_cnt once per FLUSH entry, both saturating at all-ones; cnt_clr SHALL zero both, taking priority over increment.
REQ-029 Register 0 SHALL be treated as an ordinary register for hazards.

Reset
REQ-030 rst low SHALL asynchronously force state RUN, drain counter 0, fwd_*_sel=00, stall_cnt=0, flush_cnt=0, halted=0.
REQ-031 During reset, outputs SHALL be pc_en=1, l1_en=1, l1_flush=0, l2_flush=0; reset mid-STALL/DRAIN SHALL abandon the operation with no counter update.

Structure
REQ-032 FSM state encoding, fwd-select codes (FWD_RF, FWD_L3, FWD_WB) and DRAIN_CYCLES=3 SHALL live in the shared pipeline package.
REQ-033 Forwarding compare logic SHALL be one sub-module, fwd_unit, instantiated once per operand.

Verification
REQ-034 SHALL cover: ex_memread=1, ex_rd=3, id_ra=3 used -> one cycle pc_en=0, l2_flush=1; next cycle fwd_a_sel=10; stall_cnt=1.
REQ-035 SHALL cover: ex_regwrite=1, ex_rd=5, mem_rd=5, id_rb=5 used -> fwd_b_sel=01 (ex priority).
REQ-036 SHALL cover: br_taken=1 with simultaneous load-use -> l1_flush=l2_flush=1, state FLUSH, flush_cnt=1, stall_cnt=0.
REQ-037 SHALL cover: halt_req held from RUN -> halted=1 exactly 4 clocks later; release -> pc_en=1 next cycle.
REQ-038 SHALL cover: 300 forced stalls -> stall_cnt=255; cnt_clr=1 together with a stall -> stall_cnt=0.
REQ-039 SHALL cover: rst low mid-DRAIN -> immediate RUN, halted=0, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM states, operand-forward select codes
// and the halt drain length.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [2:0] {
        StRun    = 3'd0,
        StStall  = 3'd1,
        StFlush  = 3'd2,
        StDrain  = 3'd3,
        StHalted = 3'd4
    } hz_state_e;

    // ALU operand source selects
    localparam logic [1:0] FWD_RF = 2'b00;  // register file
    localparam logic [1:0] FWD_L3 = 2'b01;  // L3 ALU result
    localparam logic [1:0] FWD_WB = 2'b10;  // writeback mux

    localparam int unsigned DRAIN_CYCLES = 3;
    // Drain counter value seen on the last DRAIN cycle
    localparam logic [1:0]  DRAIN_LAST   = 2'(DRAIN_CYCLES - 1);

    // Pipeline latch controls driven by the hazard unit
    typedef struct packed {
        logic pc_en;
        logic l1_en;
        logic l1_flush;
        logic l2_flush;
    } pipe_ctl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-side signals seen by the hazard controller.
// master: the pipeline datapath; slave: the hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 3,
    parameter int unsigned CNT_W  = 8
);
    // Stage 2 (L1 output) sources
    logic [REG_AW-1:0] id_ra;
    logic [REG_AW-1:0] id_rb;
    logic              id_uses_ra;
    logic              id_uses_rb;
    // Stage 3 (L2 output)
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    // Stage 4 (L3 output)
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwrite;
    // Control requests
    logic              br_taken;
    logic              halt_req;
    logic              cnt_clr;
    // Latch controls and status
    logic              pc_en;
    logic              l1_en;
    logic              l1_flush;
    logic              l2_flush;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              halted;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_ra, id_rb, id_uses_ra, id_uses_rb,
        output ex_rd, ex_regwrite, ex_memread,
        output mem_rd, mem_regwrite,
        output br_taken, halt_req, cnt_clr,
        input  pc_en, l1_en, l1_flush, l2_flush,
        input  fwd_a_sel, fwd_b_sel, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_ra, id_rb, id_uses_ra, id_uses_rb,
        input  ex_rd, ex_regwrite, ex_memread,
        input  mem_rd, mem_regwrite,
        input  br_taken, halt_req, cnt_clr,
        output pc_en, l1_en, l1_flush, l2_flush,
        output fwd_a_sel, fwd_b_sel, halted, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Per-operand forwarding compare. Produces the operand select for one stage-2
// source and flags a match against the stage-3 destination (used for
// load-use detection). Register 0 is an ordinary register here.
module pipe_hazard_ctrl_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 3
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic              i_uses,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_regwrite,
    input  logic              i_ex_memread,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_regwrite,
    output logic [1:0]        o_sel,
    output logic              o_ex_hit
);

    logic w_ex_match;
    logic w_mem_match;

    assign w_ex_match  = i_uses && (i_ex_rd == i_src);
    assign w_mem_match = i_uses && i_mem_regwrite && (i_mem_rd == i_src);
    assign o_ex_hit    = w_ex_match;

    // Youngest producer wins; a load in stage 3 has no result yet to forward
    always_comb begin
        o_sel = FWD_RF;
        if (w_ex_match && i_ex_regwrite && !i_ex_memread) begin
            o_sel = FWD_L3;
        end else if (w_mem_match) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stall, taken-branch
// flush, halt drain, registered operand-forward selects and event counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    pipe_hazard_ctrl_if.slave ctrl_bus
);

    hz_state_e        r_state;
    logic [1:0]       r_drain_cnt;
    logic             r_halted;
    logic [1:0]       r_fwd_a_sel;
    logic [1:0]       r_fwd_b_sel;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    pipe_ctl_t        w_ctl;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic             w_a_hit;
    logic             w_b_hit;
    logic             w_load_use;
    logic             w_enter_stall;
    logic             w_enter_flush;
    logic             w_enter_drain;

    pipe_hazard_ctrl_fwd_unit #(
        .REG_AW (REG_AW)
    ) u_fwd_unit_a (
        .i_src          (ctrl_bus.id_ra),
        .i_uses         (ctrl_bus.id_uses_ra),
        .i_ex_rd        (ctrl_bus.ex_rd),
        .i_ex_regwrite  (ctrl_bus.ex_regwrite),
        .i_ex_memread   (ctrl_bus.ex_memread),
        .i_mem_rd       (ctrl_bus.mem_rd),
        .i_mem_regwrite (ctrl_bus.mem_regwrite),
        .o_sel          (w_fwd_a),
        .o_ex_hit       (w_a_hit)
    );

    pipe_hazard_ctrl_fwd_unit #(
        .REG_AW (REG_AW)
    ) u_fwd_unit_b (
        .i_src          (ctrl_bus.id_rb),
        .i_uses         (ctrl_bus.id_uses_rb),
        .i_ex_rd        (ctrl_bus.ex_rd),
        .i_ex_regwrite  (ctrl_bus.ex_regwrite),
        .i_ex_memread   (ctrl_bus.ex_memread),
        .i_mem_rd       (ctrl_bus.mem_rd),
        .i_mem_regwrite (ctrl_bus.mem_regwrite),
        .o_sel          (w_fwd_b),
        .o_ex_hit       (w_b_hit)
    );

    assign w_load_use = ctrl_bus.ex_memread && ctrl_bus.ex_regwrite && (w_a_hit || w_b_hit);

    // Latch controls and state-entry events; held at the idle pattern in reset
    always_comb begin
        w_ctl          = '{pc_en: 1'b1, l1_en: 1'b1, l1_flush: 1'b0, l2_flush: 1'b0};
        w_enter_stall  = 1'b0;
        w_enter_flush  = 1'b0;
        w_enter_drain  = 1'b0;
        if (rst) begin
            unique case (r_state)
                StRun: begin
                    // Branch outranks load-use: the stalled instruction is squashed anyway
                    if (ctrl_bus.br_taken) begin
                        w_ctl.l1_flush = 1'b1;
                        w_ctl.l2_flush = 1'b1;
                        w_enter_flush  = 1'b1;
                    end else if (w_load_use) begin
                        w_ctl.pc_en    = 1'b0;
                        w_ctl.l1_en    = 1'b0;
                        w_ctl.l2_flush = 1'b1;
                        w_enter_stall  = 1'b1;
                    end else if (ctrl_bus.halt_req) begin
                        w_ctl.pc_en    = 1'b0;
                        w_ctl.l1_en    = 1'b0;
                        w_ctl.l1_flush = 1'b1;
                        w_enter_drain  = 1'b1;
                    end
                end
                StStall: begin
                    if (ctrl_bus.br_taken) begin
                        w_ctl.l1_flush = 1'b1;
                        w_ctl.l2_flush = 1'b1;
                        w_enter_flush  = 1'b1;
                    end
                end
                StFlush: begin
                end
                StDrain: begin
                    // Older instructions still retire; a branch among them only kills L2
                    w_ctl.pc_en    = 1'b0;
                    w_ctl.l1_en    = 1'b0;
                    w_ctl.l1_flush = 1'b1;
                    w_ctl.l2_flush = ctrl_bus.br_taken;
                end
                StHalted: begin
                    w_ctl.pc_en = 1'b0;
                    w_ctl.l1_en = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Hazard FSM with drain counter and registered halted flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StRun;
            r_drain_cnt <= 2'd0;
            r_halted    <= 1'b0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_enter_flush) begin
                        r_state <= StFlush;
                    end else if (w_enter_stall) begin
                        r_state <= StStall;
                    end else if (w_enter_drain) begin
                        r_state     <= StDrain;
                        r_drain_cnt <= 2'd0;
                    end
                end
                StStall: begin
                    r_state <= w_enter_flush ? StFlush : StRun;
                end
                StFlush: begin
                    r_state <= StRun;
                end
                StDrain: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state  <= StHalted;
                        r_halted <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end
                StHalted: begin
                    if (!ctrl_bus.halt_req) begin
                        r_state  <= StRun;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StRun;
                end
            endcase
        end
    end

    // Forward selects follow the instruction into L2; a bubble carries none
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fwd_a_sel <= FWD_RF;
            r_fwd_b_sel <= FWD_RF;
        end else if (w_ctl.l2_flush) begin
            r_fwd_a_sel <= FWD_RF;
            r_fwd_b_sel <= FWD_RF;
        end else begin
            r_fwd_a_sel <= w_fwd_a;
            r_fwd_b_sel <= w_fwd_b;
        end
    end

    // Saturating event counters; clear beats a same-cycle increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (ctrl_bus.cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_enter_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_enter_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign ctrl_bus.pc_en     = w_ctl.pc_en;
    assign ctrl_bus.l1_en     = w_ctl.l1_en;
    assign ctrl_bus.l1_flush  = w_ctl.l1_flush;
    assign ctrl_bus.l2_flush  = w_ctl.l2_flush;
    assign ctrl_bus.fwd_a_sel = r_fwd_a_sel;
    assign ctrl_bus.fwd_b_sel = r_fwd_b_sel;
    assign ctrl_bus.halted    = r_halted;
    assign ctrl_bus.stall_cnt = r_stall_cnt;
    assign ctrl_bus.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural pipeline model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned REG_AW  = 3;
    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam int          DRAIN_N = 3;

    logic clk;
    logic rst;

    pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .ctrl_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: pipeline mode as a name, remaining drain cycles, counters
    string       m_mode;
    int          m_drain;
    int          m_stall;
    int          m_flush;
    logic [1:0]  m_fa;
    logic [1:0]  m_fb;
    // Predictions for the cycle being evaluated
    logic [3:0]  e_ctl;     // {pc_en, l1_en, l1_flush, l2_flush}
    string       n_mode;
    int          n_drain;
    bit          e_inc_s;
    bit          e_inc_f;
    bit          e_clr;
    logic [1:0]  n_fa;
    logic [1:0]  n_fb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] fwd_ref(input bit uses, input logic [REG_AW-1:0] src);
        if (!uses) return 2'd0;
        if (bus.ex_regwrite && !bus.ex_memread && bus.ex_rd == src) return 2'd1;
        if (bus.mem_regwrite && bus.mem_rd == src) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_mode  = "RUN";
        m_drain = 0;
        m_stall = 0;
        m_flush = 0;
        m_fa    = 2'd0;
        m_fb    = 2'd0;
    endtask

    // Decide this cycle's controls and the next model state from current inputs
    task automatic model_eval();
        bit br;
        bit hr;
        bit lu;
        br = bus.br_taken;
        hr = bus.halt_req;
        lu = bus.ex_memread && bus.ex_regwrite &&
             ((bus.id_uses_ra && bus.ex_rd == bus.id_ra) ||
              (bus.id_uses_rb && bus.ex_rd == bus.id_rb));
        e_ctl   = 4'b1100;
        n_mode  = m_mode;
        n_drain = m_drain;
        e_inc_s = 1'b0;
        e_inc_f = 1'b0;
        e_clr   = bus.cnt_clr;
        if (m_mode == "RUN") begin
            if (br) begin
                e_ctl = 4'b1111; n_mode = "FLUSH"; e_inc_f = 1'b1;
            end else if (lu) begin
                e_ctl = 4'b0001; n_mode = "STALL"; e_inc_s = 1'b1;
            end else if (hr) begin
                e_ctl = 4'b0010; n_mode = "DRAIN"; n_drain = DRAIN_N;
            end
        end else if (m_mode == "STALL") begin
            if (br) begin
                e_ctl = 4'b1111; n_mode = "FLUSH"; e_inc_f = 1'b1;
            end else begin
                n_mode = "RUN";
            end
        end else if (m_mode == "FLUSH") begin
            n_mode = "RUN";
        end else if (m_mode == "DRAIN") begin
            e_ctl   = {3'b001, br};
            n_drain = m_drain - 1;
            if (n_drain == 0) n_mode = "HALTED";
        end else begin
            e_ctl = 4'b0000;
            if (!hr) n_mode = "RUN";
        end
        n_fa = e_ctl[0] ? 2'd0 : fwd_ref(bus.id_uses_ra, bus.id_ra);
        n_fb = e_ctl[0] ? 2'd0 : fwd_ref(bus.id_uses_rb, bus.id_rb);
    endtask

    task automatic model_commit();
        m_mode  = n_mode;
        m_drain = n_drain;
        m_fa    = n_fa;
        m_fb    = n_fb;
        if (e_clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (e_inc_s && m_stall < CNT_MAX) m_stall++;
            if (e_inc_f && m_flush < CNT_MAX) m_flush++;
        end
    endtask

    function automatic logic [31:0] dut_ctl();
        return 32'({bus.pc_en, bus.l1_en, bus.l1_flush, bus.l2_flush});
    endfunction

    // One clock: check controls mid-cycle, then registered state after the edge
    task automatic step(input string tag);
        @(negedge clk);
        model_eval();
        chk({tag, " ctl"}, dut_ctl(), 32'(e_ctl));
        @(posedge clk);
        #1;
        model_commit();
        chk({tag, " fwd_a"}, 32'(bus.fwd_a_sel), 32'(m_fa));
        chk({tag, " fwd_b"}, 32'(bus.fwd_b_sel), 32'(m_fb));
        chk({tag, " halted"}, 32'(bus.halted), 32'(m_mode == "HALTED"));
        chk({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'(m_stall));
        chk({tag, " flush_cnt"}, 32'(bus.flush_cnt), 32'(m_flush));
    endtask

    task automatic quiet();
        bus.id_ra        = '0;
        bus.id_rb        = '0;
        bus.id_uses_ra   = 1'b0;
        bus.id_uses_rb   = 1'b0;
        bus.ex_rd        = '0;
        bus.ex_regwrite  = 1'b0;
        bus.ex_memread   = 1'b0;
        bus.mem_rd       = '0;
        bus.mem_regwrite = 1'b0;
        bus.br_taken     = 1'b0;
        bus.halt_req     = 1'b0;
        bus.cnt_clr      = 1'b0;
    endtask

    task automatic set_load_use(input logic [REG_AW-1:0] rd);
        quiet();
        bus.ex_memread  = 1'b1;
        bus.ex_regwrite = 1'b1;
        bus.ex_rd       = rd;
        bus.id_ra       = rd;
        bus.id_uses_ra  = 1'b1;
    endtask

    // Asynchronous reset pulse entered mid-cycle; leaves rst high just after a rising edge
    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk({tag, " rst ctl"}, dut_ctl(), 32'h0000_000c);
        chk({tag, " rst halted"}, 32'(bus.halted), 32'd0);
        chk({tag, " rst stall_cnt"}, 32'(bus.stall_cnt), 32'd0);
        chk({tag, " rst flush_cnt"}, 32'(bus.flush_cnt), 32'd0);
        chk({tag, " rst fwd"}, 32'({bus.fwd_a_sel, bus.fwd_b_sel}), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, " rst hold ctl"}, dut_ctl(), 32'h0000_000c);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        quiet();
        model_reset();
        // Drive a branch and a load-use while reset is held: controls stay idle
        bus.br_taken = 1'b1;
        set_load_use(3'd2);
        bus.br_taken = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ctl", dut_ctl(), 32'h0000_000c);
        chk("reset halted", 32'(bus.halted), 32'd0);
        chk("reset fwd", 32'({bus.fwd_a_sel, bus.fwd_b_sel}), 32'd0);
        chk("reset cnts", 32'({bus.stall_cnt, bus.flush_cnt}), 32'd0);
        quiet();
        rst = 1'b1;

        // Load-use on r3 stalls once; producer then forwards from writeback
        set_load_use(3'd3);
        step("lu stall");
        chk("lu stall_cnt", 32'(bus.stall_cnt), 32'd1);
        quiet();
        bus.mem_rd       = 3'd3;
        bus.mem_regwrite = 1'b1;
        bus.id_ra        = 3'd3;
        bus.id_uses_ra   = 1'b1;
        step("lu resume");
        chk("lu fwd_a wb", 32'(bus.fwd_a_sel), 32'd2);

        // Both later stages write r5: stage 3 wins
        quiet();
        bus.ex_regwrite  = 1'b1;
        bus.ex_rd        = 3'd5;
        bus.mem_regwrite = 1'b1;
        bus.mem_rd       = 3'd5;
        bus.id_rb        = 3'd5;
        bus.id_uses_rb   = 1'b1;
        step("ex prio");
        chk("ex prio fwd_b", 32'(bus.fwd_b_sel), 32'd1);

        // Unused source with a matching producer still selects the register file
        bus.id_uses_rb = 1'b0;
        step("unused src");

        // Branch together with load-use: flush only
        quiet();
        bus.cnt_clr = 1'b1;
        step("clr");
        set_load_use(3'd0);
        bus.br_taken = 1'b1;
        step("br+lu");
        chk("br+lu flush_cnt", 32'(bus.flush_cnt), 32'd1);
        chk("br+lu stall_cnt", 32'(bus.stall_cnt), 32'd0);
        bus.br_taken = 1'b1;
        step("flush no reflush");
        quiet();
        step("after flush");

        // Halt held from RUN: halted appears on the fourth edge
        bus.halt_req = 1'b1;
        for (int i = 0; i < 3; i++) step("halt drain");
        chk("halt not yet", 32'(bus.halted), 32'd0);
        bus.br_taken = 1'b1;
        step("halt enter");
        chk("halt halted", 32'(bus.halted), 32'd1);
        bus.br_taken = 1'b0;
        step("halt hold");
        bus.halt_req = 1'b0;
        step("halt release");
        @(negedge clk);
        chk("release pc_en", 32'(bus.pc_en), 32'd1);
        @(posedge clk);
        #1;
        model_eval();
        model_commit();

        // 300 stalls saturate the counter; clear wins over a same-cycle stall
        for (int i = 0; i < 300; i++) begin
            set_load_use(3'(i));
            step("sat lu");
            quiet();
            step("sat run");
        end
        chk("sat stall_cnt", 32'(bus.stall_cnt), 32'd255);
        set_load_use(3'd6);
        bus.cnt_clr = 1'b1;
        step("clr+lu");
        chk("clr+lu stall_cnt", 32'(bus.stall_cnt), 32'd0);
        quiet();
        step("clr after");

        // Reset in the middle of a drain
        bus.halt_req = 1'b1;
        step("drain a");
        step("drain b");
        pulse_reset("mid drain");
        quiet();
        step("post reset");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.id_ra        = 3'($urandom_range(0, 7));
            bus.id_rb        = 3'($urandom_range(0, 7));
            bus.id_uses_ra   = ($urandom_range(0, 3) != 0);
            bus.id_uses_rb   = ($urandom_range(0, 3) != 0);
            bus.ex_rd        = 3'($urandom_range(0, 7));
            bus.ex_regwrite  = ($urandom_range(0, 1) != 0);
            bus.ex_memread   = ($urandom_range(0, 2) == 0);
            bus.mem_rd       = 3'($urandom_range(0, 7));
            bus.mem_regwrite = ($urandom_range(0, 1) != 0);
            bus.br_taken     = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) bus.halt_req = ~bus.halt_req;
            bus.cnt_clr      = ($urandom_range(0, 49) == 0);
            step("rand");
            if (i % 700 == 699) pulse_reset("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
